bp_piton_l15_return_decoder: RTL and testbench
==============================================

# bp_piton_l15_return_decoder

Receives return packets from the OpenPiton L1.5 (P-Mesh transducer return channel) and turns them into BlackParrot-side events: D$ load/atomic fills, I$ fills, write-through store acknowledgements and coherence invalidations. It sits between the L1.5 and the write-through, coherent L1 caches of the unicore ParrotPiton configuration (L2 disabled, all AMOs resolved at L2/L1.5). It is the response-side counterpart of the request encoder that issues BP cache misses and stores to the L1.5.

## Interface
Parameters:
- `icache_fill_width_p`, 256, I$ fill width; one L1.5 beat.
- `dcache_fill_width_p`, 128, D$ fill width; low 128 bits of the beat.
- `st_credits_p`, 8, maximum outstanding write-through stores.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  clock
- `reset_n_i`  in  1  asynchronous active-low reset
- `l15_val_i`  in  1  return packet valid
- `l15_returntype_i`  in  4  return type
- `l15_noncacheable_i`  in  1  NC flag
- `l15_data_i`  in  256  return data {data_3,…,data_0}
- `l15_inval_icache_i` / `l15_inval_dcache_i`  in  1 each  invalidate target
- `l15_inval_addr_15_4_i`  in  12  invalidation index
- `l15_inval_way_i`  in  2  invalidation way
- `l15_ack_o`  out  1  packet accepted this cycle
- `dfill_v_o`, `dfill_data_o[127:0]`, `dfill_nc_o`, `dfill_amo_o`  out  D$ fill
- `dfill_ready_and_i`  in  1
- `ifill_v_o`, `ifill_data_o[255:0]`  out  I$ fill
- `ifill_ready_and_i`  in  1
- `inval_v_o`, `inval_icache_o`, `inval_dcache_o`, `inval_addr_o[11:0]`, `inval_way_o[1:0]`  out  invalidation command
- `inval_ready_and_i`  in  1
- `st_sent_i`  in  1  one store issued to L1.5 this cycle
- `st_ready_o`  out  1  store credit available
- `st_empty_o`  out  1  no stores outstanding (fence drain)
- `err_o`  out  1  one-cycle error pulse

## Operation
- Input buffered in a 2-entry FIFO; `l15_ack_o = l15_val_i & ~full`.
- FSM on FIFO head: `e_idle`, `e_dispatch`, `e_inval`, `e_ack`.
  - `e_idle`: FIFO empty; -> `e_dispatch` when head valid.
  - LOAD_RET (0000) / AT_RET (0101): assert `dfill_v_o` (`dfill_amo_o`=1 for AT_RET); pop on `dfill_ready_and_i`.
  - IFILL_RET (0001): assert `ifill_v_o`; pop on `ifill_ready_and_i`.
  - EVICT_REQ (0011): -> `e_inval`; assert `inval_v_o`; pop on `inval_ready_and_i`.
  - ST_ACK (0100): if either inval flag set -> `e_inval` first, then `e_ack`; else direct `e_ack`. `e_ack`: decrement store counter, pop, no handshake.
  - Any other type: pop, pulse `err_o`.
- After a pop: -> `e_dispatch` if FIFO non-empty, else `e_idle`.
- Store counter (0..`st_credits_p`): +1 on `st_sent_i`, −1 on ST_ACK pop; both in the same cycle -> unchanged. `st_ready_o = count < st_credits_p`; `st_empty_o = count == 0`.
- ST_ACK with count 0: counter stays 0, `err_o` pulses. `st_sent_i` while `~st_ready_o`: ignored, `err_o` pulses.

## Timing
- Reset: FIFO empty, state `e_idle`, count 0; all `*_v_o`, `l15_ack_o`, `err_o` = 0; `st_ready_o` = 1; `st_empty_o` = 1; data outputs 0.
- Latency: L1.5 accept to output valid = 1 cycle (registered FIFO head). Back-to-back packets sustain 1 pop/cycle when the consumer is ready.
- Output valids hold, with data stable, until handshake; no valid drops without ready.
- FIFO push and pop in the same cycle while full is allowed (ack = 1 if pop frees a slot is NOT used; ack depends on registered full only).
- Reset asserted mid-handshake: all state cleared immediately (async); in-flight packets are lost; counter returns to 0.

## Structure
- Shared package `bp_piton_l15_pkg`: `bp_l15_returntype_e` enum (values above), `bp_l15_return_s` packet struct (type, nc, data, inval fields).
- One sub-module: `bsg_two_fifo` for the input buffer; FSM, decode and counter in the top.

## Test plan
- LOAD_RET, data 0xA5…A5, dfill ready -> `l15_ack_o` same cycle, `dfill_v_o` next cycle with low 128 bits, `dfill_amo_o`=0.
- IFILL_RET with `ifill_ready_and_i` low 5 cycles -> `ifill_v_o` held 6 cycles with stable 256-bit data; second packet accepted, third stalls `l15_ack_o`=0.
- ST_ACK with `l15_inval_dcache_i`=1, addr 0x3F0, way 2 -> `inval_v_o` with those fields, after handshake count decrements by 1.
- 8 `st_sent_i` pulses -> `st_ready_o`=0; ST_ACK and `st_sent_i` same cycle -> count stays 8; 8 ST_ACKs -> `st_empty_o`=1.
- ST_ACK at count 0 and returntype 1100 -> `err_o` pulse each, count stays 0, FIFO drains.
- `reset_n_i` low while `dfill_v_o`=1 -> outputs zero asynchronously, `st_empty_o`=1, next packet processed normally after release.

Source files
------------

// File: rtl/bp_piton_l15_pkg.sv
// Shared definitions for the BlackParrot <-> OpenPiton L1.5 return path.
//   bp_l15_returntype_e : L1.5 return packet types consumed on the BP side
//   bp_l15_return_s     : one buffered return packet (type, NC flag, data,
//                         invalidation target/index/way)
//   bp_l15_dec_state_e  : return decoder dispatch states
package bp_piton_l15_pkg;

   localparam int l15_data_width_gp       = 256;
   localparam int l15_inval_addr_width_gp = 12;
   localparam int l15_inval_way_width_gp  = 2;

   typedef enum logic [3:0] {
      e_load_ret  = 4'b0000,
      e_ifill_ret = 4'b0001,
      e_evict_req = 4'b0011,
      e_st_ack    = 4'b0100,
      e_at_ret    = 4'b0101
   } bp_l15_returntype_e;

   // The type field is kept as raw bits so that undefined encodings survive
   // buffering and can be flagged as errors when they reach the head.
   typedef struct packed {
      logic [3:0]                          returntype;
      logic                                nc;
      logic [l15_data_width_gp-1:0]        data;
      logic                                inval_icache;
      logic                                inval_dcache;
      logic [l15_inval_addr_width_gp-1:0]  inval_addr;
      logic [l15_inval_way_width_gp-1:0]   inval_way;
   } bp_l15_return_s;

   typedef enum logic [1:0] {
      e_idle,
      e_dispatch,
      e_inval,
      e_ack
   } bp_l15_dec_state_e;

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry ready/valid FIFO with a registered head.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i, data_i      : enqueue side; accepted when ready_o is high
//   ready_o          : FIFO not full (registered, independent of yumi_i)
//   v_o, data_o      : head entry
//   yumi_i           : consumer takes the head this cycle
module bsg_two_fifo #(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   logic [width_p-1:0] mem_r [2];
   logic               rd_ptr_r;
   logic               wr_ptr_r;
   logic               full_r;
   logic               empty_r;
   logic               enq;
   logic               deq;

   assign enq = v_i & ~full_r;
   assign deq = yumi_i & ~empty_r;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_ptr_r <= 1'b0;
         wr_ptr_r <= 1'b0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (enq) wr_ptr_r <= ~wr_ptr_r;
         if (deq) rd_ptr_r <= ~rd_ptr_r;
         if (enq & ~deq) begin
            empty_r <= 1'b0;
            full_r  <= (~wr_ptr_r == rd_ptr_r);
         end else if (deq & ~enq) begin
            full_r  <= 1'b0;
            empty_r <= (~rd_ptr_r == wr_ptr_r);
         end
      end
   end

   // NOTE: the storage array has no reset; its contents are only observed
   // behind v_o, so clearing it would buy nothing but reset fan-out.
   always_ff @(posedge clk_i) begin
      if (enq) mem_r[wr_ptr_r] <= data_i;
   end

   assign ready_o = ~full_r;
   assign v_o     = ~empty_r;
   assign data_o  = mem_r[rd_ptr_r];

endmodule

// File: rtl/bp_piton_l15_return_decoder.sv
// Turns OpenPiton L1.5 return packets into BlackParrot cache events.
//   clk_i, reset_n_i          : clock, asynchronous active-low reset
//   l15_*_i, l15_ack_o        : L1.5 return channel (valid/ack)
//   dfill_*                   : D$ load/atomic fill (valid/ready)
//   ifill_*                   : I$ fill (valid/ready)
//   inval_*                   : coherence invalidation command (valid/ready)
//   st_sent_i                 : one write-through store issued this cycle
//   st_ready_o, st_empty_o    : store credit available / no stores in flight
//   err_o                     : one-cycle pulse on a protocol error
module bp_piton_l15_return_decoder
   import bp_piton_l15_pkg::*;
#(
   parameter int icache_fill_width_p = 256,
   parameter int dcache_fill_width_p = 128,
   parameter int st_credits_p        = 8
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           l15_val_i,
   input  logic [3:0]                     l15_returntype_i,
   input  logic                           l15_noncacheable_i,
   input  logic [l15_data_width_gp-1:0]   l15_data_i,
   input  logic                           l15_inval_icache_i,
   input  logic                           l15_inval_dcache_i,
   input  logic [11:0]                    l15_inval_addr_15_4_i,
   input  logic [1:0]                     l15_inval_way_i,
   output logic                           l15_ack_o,
   output logic                           dfill_v_o,
   output logic [dcache_fill_width_p-1:0] dfill_data_o,
   output logic                           dfill_nc_o,
   output logic                           dfill_amo_o,
   input  logic                           dfill_ready_and_i,
   output logic                           ifill_v_o,
   output logic [icache_fill_width_p-1:0] ifill_data_o,
   input  logic                           ifill_ready_and_i,
   output logic                           inval_v_o,
   output logic                           inval_icache_o,
   output logic                           inval_dcache_o,
   output logic [11:0]                    inval_addr_o,
   output logic [1:0]                     inval_way_o,
   input  logic                           inval_ready_and_i,
   input  logic                           st_sent_i,
   output logic                           st_ready_o,
   output logic                           st_empty_o,
   output logic                           err_o
);

   localparam int packet_width_lp = $bits(bp_l15_return_s);
   localparam int count_width_lp  = $clog2(st_credits_p + 1);
   localparam logic [count_width_lp-1:0] credits_lp = count_width_lp'(st_credits_p);

   // ---------------- input buffer ----------------
   bp_l15_return_s               enq_pkt;
   bp_l15_return_s               head;
   logic [packet_width_lp-1:0]   head_raw;
   logic                         head_v;
   logic                         fifo_ready;
   logic                         pop;

   assign enq_pkt.returntype   = l15_returntype_i;
   assign enq_pkt.nc           = l15_noncacheable_i;
   assign enq_pkt.data         = l15_data_i;
   assign enq_pkt.inval_icache = l15_inval_icache_i;
   assign enq_pkt.inval_dcache = l15_inval_dcache_i;
   assign enq_pkt.inval_addr   = l15_inval_addr_15_4_i;
   assign enq_pkt.inval_way    = l15_inval_way_i;

   // Acceptance looks only at the registered full flag, never at this
   // cycle's pop, to keep the ack off the consumer-ready paths.
   assign l15_ack_o = l15_val_i & fifo_ready;

   bsg_two_fifo #(
      .width_p (packet_width_lp)
   ) input_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (l15_val_i),
      .data_i    (enq_pkt),
      .ready_o   (fifo_ready),
      .v_o       (head_v),
      .data_o    (head_raw),
      .yumi_i    (pop)
   );

   assign head = bp_l15_return_s'(head_raw);

   // ---------------- dispatch FSM ----------------
   bp_l15_dec_state_e state_r;
   bp_l15_dec_state_e state_n;
   logic              dfill_v;
   logic              ifill_v;
   logic              inval_v;
   logic              st_ack_pop;
   logic              type_err;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_r <= e_idle;
      else            state_r <= state_n;
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_n    = state_r;
      pop        = 1'b0;
      dfill_v    = 1'b0;
      ifill_v    = 1'b0;
      inval_v    = 1'b0;
      st_ack_pop = 1'b0;
      type_err   = 1'b0;

      case (state_r)
         // A head that lands while idle is decoded in the same cycle, giving
         // one cycle from L1.5 accept to fill valid.
         e_idle, e_dispatch: begin
            if (!head_v) begin
               state_n = e_idle;
            end else begin
               state_n = e_dispatch;
               case (head.returntype)
                  e_load_ret, e_at_ret: begin
                     dfill_v = 1'b1;
                     pop     = dfill_ready_and_i;
                  end
                  e_ifill_ret: begin
                     ifill_v = 1'b1;
                     pop     = ifill_ready_and_i;
                  end
                  e_evict_req: state_n = e_inval;
                  e_st_ack: state_n = (head.inval_icache | head.inval_dcache) ? e_inval : e_ack;
                  default: begin
                     pop      = 1'b1;
                     type_err = 1'b1;
                  end
               endcase
            end
         end
         e_inval: begin
            inval_v = 1'b1;
            if (inval_ready_and_i) begin
               // A store ack carrying an invalidation still has to return
               // its credit before it leaves the FIFO.
               if (head.returntype == e_st_ack) state_n = e_ack;
               else                             pop     = 1'b1;
            end
         end
         e_ack: begin
            pop        = 1'b1;
            st_ack_pop = 1'b1;
         end
         default: state_n = e_idle;
      endcase

      // After a pop the FIFO still holds a packet if it was full or one is
      // being pushed in this same cycle.
      if (pop) state_n = (~fifo_ready | l15_ack_o) ? e_dispatch : e_idle;
   end

   // ---------------- store credit counter ----------------
   logic [count_width_lp-1:0] st_count_r;
   logic                      st_inc;
   logic                      st_dec;

   assign st_ready_o = (st_count_r < credits_lp);
   assign st_empty_o = (st_count_r == '0);
   assign st_dec     = st_ack_pop & ~st_empty_o;
   // A store issued in the cycle an ack returns a credit takes that credit
   // directly, so it is legal even at the credit limit.
   assign st_inc     = st_sent_i & (st_ready_o | st_dec);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)            st_count_r <= '0;
      else if (st_inc & ~st_dec) st_count_r <= st_count_r + count_width_lp'(1);
      else if (st_dec & ~st_inc) st_count_r <= st_count_r - count_width_lp'(1);
   end

   assign err_o = type_err | (st_ack_pop & st_empty_o) | (st_sent_i & ~st_inc);

   // ---------------- outputs ----------------
   // Payloads are zeroed when not valid so they read 0 out of reset.
   assign dfill_v_o      = dfill_v;
   assign dfill_data_o   = dfill_v ? head.data[dcache_fill_width_p-1:0] : '0;
   assign dfill_nc_o     = dfill_v & head.nc;
   assign dfill_amo_o    = dfill_v & (head.returntype == e_at_ret);
   assign ifill_v_o      = ifill_v;
   assign ifill_data_o   = ifill_v ? head.data[icache_fill_width_p-1:0] : '0;
   assign inval_v_o      = inval_v;
   assign inval_icache_o = inval_v & head.inval_icache;
   assign inval_dcache_o = inval_v & head.inval_dcache;
   assign inval_addr_o   = inval_v ? head.inval_addr : '0;
   assign inval_way_o    = inval_v ? head.inval_way : '0;

endmodule

// File: tb/tb_bp_piton_l15_return_decoder.sv
// Self-checking bench for bp_piton_l15_return_decoder: directed scenarios
// followed by a randomized phase scored against a packet-queue model.
module tb_bp_piton_l15_return_decoder;
   import bp_piton_l15_pkg::*;

   logic         clk;
   logic         reset_n_i;
   logic         l15_val_i;
   logic [3:0]   l15_returntype_i;
   logic         l15_noncacheable_i;
   logic [255:0] l15_data_i;
   logic         l15_inval_icache_i;
   logic         l15_inval_dcache_i;
   logic [11:0]  l15_inval_addr_15_4_i;
   logic [1:0]   l15_inval_way_i;
   logic         l15_ack_o;
   logic         dfill_v_o;
   logic [127:0] dfill_data_o;
   logic         dfill_nc_o;
   logic         dfill_amo_o;
   logic         dfill_ready_and_i;
   logic         ifill_v_o;
   logic [255:0] ifill_data_o;
   logic         ifill_ready_and_i;
   logic         inval_v_o;
   logic         inval_icache_o;
   logic         inval_dcache_o;
   logic [11:0]  inval_addr_o;
   logic [1:0]   inval_way_o;
   logic         inval_ready_and_i;
   logic         st_sent_i;
   logic         st_ready_o;
   logic         st_empty_o;
   logic         err_o;

   int n_checks = 0;
   int n_fail   = 0;

   bp_piton_l15_return_decoder #(
      .icache_fill_width_p (256),
      .dcache_fill_width_p (128),
      .st_credits_p        (8)
   ) dut (
      .clk_i                 (clk),
      .reset_n_i             (reset_n_i),
      .l15_val_i             (l15_val_i),
      .l15_returntype_i      (l15_returntype_i),
      .l15_noncacheable_i    (l15_noncacheable_i),
      .l15_data_i            (l15_data_i),
      .l15_inval_icache_i    (l15_inval_icache_i),
      .l15_inval_dcache_i    (l15_inval_dcache_i),
      .l15_inval_addr_15_4_i (l15_inval_addr_15_4_i),
      .l15_inval_way_i       (l15_inval_way_i),
      .l15_ack_o             (l15_ack_o),
      .dfill_v_o             (dfill_v_o),
      .dfill_data_o          (dfill_data_o),
      .dfill_nc_o            (dfill_nc_o),
      .dfill_amo_o           (dfill_amo_o),
      .dfill_ready_and_i     (dfill_ready_and_i),
      .ifill_v_o             (ifill_v_o),
      .ifill_data_o          (ifill_data_o),
      .ifill_ready_and_i     (ifill_ready_and_i),
      .inval_v_o             (inval_v_o),
      .inval_icache_o        (inval_icache_o),
      .inval_dcache_o        (inval_dcache_o),
      .inval_addr_o          (inval_addr_o),
      .inval_way_o           (inval_way_o),
      .inval_ready_and_i     (inval_ready_and_i),
      .st_sent_i             (st_sent_i),
      .st_ready_o            (st_ready_o),
      .st_empty_o            (st_empty_o),
      .err_o                 (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic bp_l15_return_s mk(input logic [3:0] t, input logic [255:0] d,
                                         input logic nc, input logic ic, input logic dc,
                                         input logic [11:0] a, input logic [1:0] w);
      bp_l15_return_s p;
      p.returntype   = t;
      p.data         = d;
      p.nc           = nc;
      p.inval_icache = ic;
      p.inval_dcache = dc;
      p.inval_addr   = a;
      p.inval_way    = w;
      return p;
   endfunction

   task automatic drive_pkt(input bp_l15_return_s p);
      l15_returntype_i      = p.returntype;
      l15_data_i            = p.data;
      l15_noncacheable_i    = p.nc;
      l15_inval_icache_i    = p.inval_icache;
      l15_inval_dcache_i    = p.inval_dcache;
      l15_inval_addr_15_4_i = p.inval_addr;
      l15_inval_way_i       = p.inval_way;
   endtask

   // Present a packet until the L1.5 side accepts it; returns just after
   // the accepting edge with valid dropped.
   task automatic send(input bp_l15_return_s p);
      bit accepted = 1'b0;
      drive_pkt(p);
      l15_val_i = 1'b1;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (l15_ack_o) begin
            accepted = 1'b1;
            break;
         end
         cyc();
      end
      check("send_accepted", accepted, 1'b1);
      cyc();
      l15_val_i = 1'b0;
   endtask

   // ---------------- randomized phase model ----------------
   bp_l15_return_s mq[$];
   bp_l15_return_s cur;
   bit             holding = 1'b0;
   bit             d_stall = 1'b0, i_stall = 1'b0, v_stall = 1'b0;
   logic [127:0]   d_hold;
   logic [255:0]   i_hold;
   logic [15:0]    v_hold;
   logic [3:0]     rand_types [6] = '{4'h0, 4'h1, 4'h3, 4'h5, 4'hC, 4'h2};

   // Which consumer a packet type is routed to: 0 D$ fill, 1 I$ fill,
   // 2 invalidation, 3 error drop.
   function automatic int kind_of(input logic [3:0] t);
      if (t == 4'h0 || t == 4'h5) return 0;
      if (t == 4'h1) return 1;
      if (t == 4'h3) return 2;
      return 3;
   endfunction

   task automatic rand_cycle(input bit allow_new);
      int             occ;
      int             n_ev;
      int             obs_k;
      bp_l15_return_s e;
      if (allow_new && !holding && $urandom_range(0, 2) != 0) begin
         cur = mk(rand_types[$urandom_range(0, 5)], rand256(), 1'($urandom),
                  1'($urandom), 1'($urandom), 12'($urandom), 2'($urandom));
         holding = 1'b1;
      end
      l15_val_i = holding;
      drive_pkt(cur);
      dfill_ready_and_i = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
      ifill_ready_and_i = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
      inval_ready_and_i = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      occ = mq.size();
      check("rand_ack", l15_ack_o, l15_val_i && (occ < 2));
      if (d_stall) begin
         check("dfill_hold_v", dfill_v_o, 1'b1);
         check("dfill_hold_data", dfill_data_o, d_hold);
      end
      if (i_stall) begin
         check("ifill_hold_v", ifill_v_o, 1'b1);
         check("ifill_hold_data", ifill_data_o, i_hold);
      end
      if (v_stall) begin
         check("inval_hold_v", inval_v_o, 1'b1);
         check("inval_hold_fields", {inval_icache_o, inval_dcache_o, inval_addr_o, inval_way_o}, v_hold);
      end
      n_ev = int'(dfill_v_o) + int'(ifill_v_o) + int'(inval_v_o) + int'(err_o);
      if (n_ev != 0) begin
         check("single_event", n_ev, 1);
         check("event_has_packet", occ != 0, 1'b1);
         if (occ != 0) begin
            e = mq[0];
            obs_k = dfill_v_o ? 0 : ifill_v_o ? 1 : inval_v_o ? 2 : 3;
            check("event_kind", obs_k, kind_of(e.returntype));
            if (dfill_v_o) begin
               check("rand_dfill_data", dfill_data_o, e.data[127:0]);
               check("rand_dfill_amo", dfill_amo_o, e.returntype == 4'h5);
               check("rand_dfill_nc", dfill_nc_o, e.nc);
               if (dfill_ready_and_i) void'(mq.pop_front());
            end else if (ifill_v_o) begin
               check("rand_ifill_data", ifill_data_o, e.data);
               if (ifill_ready_and_i) void'(mq.pop_front());
            end else if (inval_v_o) begin
               check("rand_inval_fields", {inval_icache_o, inval_dcache_o, inval_addr_o, inval_way_o},
                     {e.inval_icache, e.inval_dcache, e.inval_addr, e.inval_way});
               if (inval_ready_and_i) void'(mq.pop_front());
            end else begin
               void'(mq.pop_front());
            end
         end
      end
      if (l15_val_i && l15_ack_o) begin
         mq.push_back(cur);
         holding = 1'b0;
      end
      d_stall = dfill_v_o & ~dfill_ready_and_i;
      i_stall = ifill_v_o & ~ifill_ready_and_i;
      v_stall = inval_v_o & ~inval_ready_and_i;
      d_hold  = dfill_data_o;
      i_hold  = ifill_data_o;
      v_hold  = {inval_icache_o, inval_dcache_o, inval_addr_o, inval_way_o};
      cyc();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [255:0] d1, d2, d3;
      bit           found;
      int           errs;

      reset_n_i             = 1'b0;
      l15_val_i             = 1'b0;
      l15_returntype_i      = 4'h0;
      l15_noncacheable_i    = 1'b0;
      l15_data_i            = '0;
      l15_inval_icache_i    = 1'b0;
      l15_inval_dcache_i    = 1'b0;
      l15_inval_addr_15_4_i = '0;
      l15_inval_way_i       = '0;
      dfill_ready_and_i     = 1'b0;
      ifill_ready_and_i     = 1'b0;
      inval_ready_and_i     = 1'b0;
      st_sent_i             = 1'b0;

      // Reset state
      #12;
      check("rst_ack", l15_ack_o, 1'b0);
      check("rst_dfill_v", dfill_v_o, 1'b0);
      check("rst_ifill_v", ifill_v_o, 1'b0);
      check("rst_inval_v", inval_v_o, 1'b0);
      check("rst_err", err_o, 1'b0);
      check("rst_st_ready", st_ready_o, 1'b1);
      check("rst_st_empty", st_empty_o, 1'b1);
      check("rst_dfill_data", dfill_data_o, '0);
      check("rst_ifill_data", ifill_data_o, '0);
      reset_n_i = 1'b1;
      cyc();

      // LOAD_RET: ack same cycle, fill next cycle with low 128 bits
      dfill_ready_and_i = 1'b1;
      drive_pkt(mk(4'h0, {32{8'hA5}}, 1'b1, 1'b0, 1'b0, 12'h0, 2'h0));
      l15_val_i = 1'b1;
      #1;
      check("load_ack", l15_ack_o, 1'b1);
      cyc();
      l15_val_i = 1'b0;
      #1;
      check("load_dfill_v", dfill_v_o, 1'b1);
      check("load_dfill_data", dfill_data_o, {16{8'hA5}});
      check("load_dfill_amo", dfill_amo_o, 1'b0);
      check("load_dfill_nc", dfill_nc_o, 1'b1);
      cyc();
      #1;
      check("load_popped", dfill_v_o, 1'b0);

      // IFILL_RET with the I$ stalled for 5 cycles
      d1 = rand256();
      d2 = rand256();
      d3 = rand256();
      ifill_ready_and_i = 1'b0;
      cyc();
      drive_pkt(mk(4'h1, d1, 1'b0, 1'b0, 1'b0, 12'h0, 2'h0));
      l15_val_i = 1'b1;
      #1;
      check("ifill_ack1", l15_ack_o, 1'b1);
      cyc();
      drive_pkt(mk(4'h1, d2, 1'b0, 1'b0, 1'b0, 12'h0, 2'h0));
      #1;
      check("ifill_ack2", l15_ack_o, 1'b1);
      check("ifill_hold_v_1", ifill_v_o, 1'b1);
      check("ifill_hold_d_1", ifill_data_o, d1);
      cyc();
      drive_pkt(mk(4'h1, d3, 1'b0, 1'b0, 1'b0, 12'h0, 2'h0));
      #1;
      check("ifill_stall_ack3", l15_ack_o, 1'b0);
      check("ifill_hold_v_2", ifill_v_o, 1'b1);
      check("ifill_hold_d_2", ifill_data_o, d1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         if (i == 3) ifill_ready_and_i = 1'b1;
         #1;
         check("ifill_hold_v_n", ifill_v_o, 1'b1);
         check("ifill_hold_d_n", ifill_data_o, d1);
         check("ifill_stall_ack_n", l15_ack_o, 1'b0);
      end
      cyc();
      #1;
      check("ifill_ack3_late", l15_ack_o, 1'b1);
      check("ifill_second", ifill_data_o, d2);
      cyc();
      l15_val_i = 1'b0;
      #1;
      check("ifill_third", ifill_data_o, d3);
      cyc();
      #1;
      check("ifill_drained", ifill_v_o, 1'b0);

      // ST_ACK carrying a D$ invalidation
      cyc();
      st_sent_i = 1'b1;
      cyc();
      st_sent_i = 1'b0;
      #1;
      check("one_store_not_empty", st_empty_o, 1'b0);
      cyc();
      send(mk(4'h4, '0, 1'b0, 1'b0, 1'b1, 12'h3F0, 2'd2));
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (inval_v_o) begin
            found = 1'b1;
            break;
         end
         cyc();
      end
      check("stack_inval_seen", found, 1'b1);
      check("stack_inval_dcache", inval_dcache_o, 1'b1);
      check("stack_inval_icache", inval_icache_o, 1'b0);
      check("stack_inval_addr", inval_addr_o, 12'h3F0);
      check("stack_inval_way", inval_way_o, 2'd2);
      check("stack_count_before", st_empty_o, 1'b0);
      cyc();
      #1;
      check("stack_inval_held", inval_v_o, 1'b1);
      inval_ready_and_i = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         #1;
         if (st_empty_o) begin
            found = 1'b1;
            break;
         end
      end
      check("stack_count_dec", found, 1'b1);
      check("stack_inval_done", inval_v_o, 1'b0);

      // Credit limit
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (i == 7) begin
            #1;
            check("ready_at_7", st_ready_o, 1'b1);
         end
         st_sent_i = 1'b1;
      end
      cyc();
      st_sent_i = 1'b0;
      #1;
      check("credits_full_ready", st_ready_o, 1'b0);
      check("credits_full_empty", st_empty_o, 1'b0);
      st_sent_i = 1'b1;
      #1;
      check("overflow_err", err_o, 1'b1);
      cyc();
      st_sent_i = 1'b0;
      #1;
      check("overflow_ignored", st_ready_o, 1'b0);
      check("overflow_err_clear", err_o, 1'b0);

      // ST_ACK retires in the same cycle a new store is sent
      cyc();
      send(mk(4'h4, '0, 1'b0, 1'b0, 1'b0, 12'h0, 2'h0));
      cyc();
      st_sent_i = 1'b1;
      cyc();
      st_sent_i = 1'b0;
      #1;
      check("simul_count_ready", st_ready_o, 1'b0);

      // Drain eight credits
      for (int i = 0; i < 7; i++) send(mk(4'h4, '0, 1'b0, 1'b0, 1'b0, 12'h0, 2'h0));
      for (int i = 0; i < 20; i++) cyc();
      check("after7_not_empty", st_empty_o, 1'b0);
      check("after7_ready", st_ready_o, 1'b1);
      send(mk(4'h4, '0, 1'b0, 1'b0, 1'b0, 12'h0, 2'h0));
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (st_empty_o) begin
            found = 1'b1;
            break;
         end
         cyc();
      end
      check("after8_empty", found, 1'b1);

      // ST_ACK at zero credits and an undefined return type
      cyc();
      send(mk(4'h4, '0, 1'b0, 1'b0, 1'b0, 12'h0, 2'h0));
      send(mk(4'hC, rand256(), 1'b0, 1'b0, 1'b0, 12'h0, 2'h0));
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (err_o) errs++;
         cyc();
      end
      check("err_pulses", errs, 2);
      check("err_count_zero", st_empty_o, 1'b1);
      check("err_ready", st_ready_o, 1'b1);

      // Asynchronous reset during a pending D$ fill
      dfill_ready_and_i = 1'b0;
      st_sent_i = 1'b1;
      cyc();
      st_sent_i = 1'b0;
      d1 = rand256();
      send(mk(4'h0, d1, 1'b0, 1'b0, 1'b0, 12'h0, 2'h0));
      #1;
      check("pre_reset_dfill_v", dfill_v_o, 1'b1);
      check("pre_reset_not_empty", st_empty_o, 1'b0);
      #1;
      reset_n_i = 1'b0;
      #1;
      check("async_rst_dfill_v", dfill_v_o, 1'b0);
      check("async_rst_dfill_data", dfill_data_o, '0);
      check("async_rst_empty", st_empty_o, 1'b1);
      check("async_rst_ready", st_ready_o, 1'b1);
      cyc();
      cyc();
      reset_n_i = 1'b1;
      dfill_ready_and_i = 1'b1;
      cyc();
      d2 = rand256();
      send(mk(4'h5, d2, 1'b0, 1'b0, 1'b0, 12'h0, 2'h0));
      #1;
      check("post_rst_dfill_v", dfill_v_o, 1'b1);
      check("post_rst_dfill_data", dfill_data_o, d2[127:0]);
      check("post_rst_amo", dfill_amo_o, 1'b1);
      cyc();

      // Randomized traffic against the queue model
      for (int i = 0; i < 400; i++) rand_cycle(1'b1);
      for (int i = 0; i < 60; i++) begin
         if (mq.size() == 0 && !holding) break;
         rand_cycle(1'b0);
      end
      check("rand_drain_queue", mq.size(), 0);
      check("rand_drain_holding", holding, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
